// File: rtl/note_sequencer.sv
`timescale 1ns/1ps
// Purpose: plays a song from sync-read pattern memory and drives one square channel's note interface.
// Latency: start in cycle N -> rom_addr valid N+1, word captured end of N+2, note_rst/outputs in N+3.
// Backpressure: none; the channel is a pure consumer, timing is set by the note_clk tick divider.
//
// Ports:
//   clk50mhz, rst        system clock, synchronous active-high reset
//   start, stop          begin playback at start_addr (ignored while busy) / abort playback
//   start_addr           first event address
//   rom_addr, rom_data   registered pattern memory address, 24-bit event word (valid one cycle later)
//   busy, done           playback in progress, 1-cycle pulse on END
//   note_clk, note_rst   tick clock to channel (period 2*TICK_DIV), 1-cycle note trigger
//   note_in .. fx_optB   channel note/envelope/effect controls, held until the next NOTE or rst
//
// Event word: op[23:22] 00=NOTE 01=REST 10=LOOP 11=END.
//   NOTE: note[21:16] len[15:13] atk[12:11] dec[10:9] fx[8:7] A[6:5] B[4:3] dur[2:0]
//   REST: dur[2:0].  LOOP: target[ADDR_W-1:0] (ADDR_W <= 22).  END: no fields.
module note_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 390625
) (
  input  logic              clk50mhz,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              busy,
  output logic              done,
  output logic              note_clk,
  output logic              note_rst,
  output logic [5:0]        note_in,
  output logic [2:0]        note_length,
  output logic [1:0]        env_atk,
  output logic [1:0]        env_dec,
  output logic [1:0]        fx_sel,
  output logic [1:0]        fx_optA,
  output logic [1:0]        fx_optB
);

  localparam int PERIOD = 2 * TICK_DIV;
  localparam int DIV_W  = $clog2(PERIOD);

  // Divider phases within one note_clk period (count 0 is the cycle after a tick).
  localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(PERIOD - 1);   // tick: note_clk 0->1
  localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(TICK_DIV - 1); // note_clk 1->0
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(1);            // register channel outputs
  localparam logic [DIV_W-1:0] DIV_GO   = DIV_W'(2);            // note_rst visible, enter PLAY

  localparam logic [1:0] OP_NOTE = 2'b00;
  localparam logic [1:0] OP_REST = 2'b01;
  localparam logic [1:0] OP_LOOP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_PLAY
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       dcnt;
  logic [23:0]      ev_q;

  logic             tick;
  logic             load_slot;
  logic [1:0]       cur_op;
  logic [18:0]      cur_fields;

  assign tick = busy && (div_cnt == DIV_TOP);

  // Outputs are committed on a fixed divider phase so every note_rst lands exactly
  // three cycles after a tick (or after start). In the normal path the word is
  // still on rom_data when that phase comes round; after a LOOP the extra fetch
  // pushes it into EXEC, where the latched copy waits for the next period.
  assign load_slot  = (div_cnt == DIV_LOAD) && !stop &&
                      ((state == S_LATCH) || (state == S_EXEC));
  assign cur_op     = (state == S_LATCH) ? rom_data[23:22] : ev_q[23:22];
  assign cur_fields = (state == S_LATCH) ? rom_data[21:3]  : ev_q[21:3];

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      dcnt        <= '0;
      ev_q        <= '0;
      rom_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      note_clk    <= 1'b0;
      note_rst    <= 1'b0;
      note_in     <= '0;
      note_length <= '0;
      env_atk     <= '0;
      env_dec     <= '0;
      fx_sel      <= '0;
      fx_optA     <= '0;
      fx_optB     <= '0;
    end else begin
      note_rst <= 1'b0;
      done     <= 1'b0;

      // Free-running while busy. note_clk is forced low at start, so the first
      // rising edge comes one full period later; that gives the first event the
      // same tick budget as every later one.
      if (busy) begin
        if (div_cnt == DIV_TOP) begin
          div_cnt  <= '0;
          note_clk <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
          if (div_cnt == DIV_FALL) begin
            note_clk <= 1'b0;
          end
        end
      end

      if (load_slot && (cur_op == OP_NOTE)) begin
        note_in     <= cur_fields[18:13];
        note_length <= cur_fields[12:10];
        env_atk     <= cur_fields[9:8];
        env_dec     <= cur_fields[7:6];
        fx_sel      <= cur_fields[5:4];
        fx_optA     <= cur_fields[3:2];
        fx_optB     <= cur_fields[1:0];
        note_rst    <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            rom_addr <= start_addr;
            div_cnt  <= '0;
            note_clk <= 1'b0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          ev_q  <= rom_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (ev_q[23:22])
            OP_NOTE, OP_REST: begin
              if (div_cnt == DIV_GO) begin
                dcnt  <= ev_q[2:0];
                state <= S_PLAY;
              end
            end
            OP_LOOP: begin
              rom_addr <= ev_q[ADDR_W-1:0];
              state    <= S_FETCH;
            end
            default: begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          endcase
        end
        S_PLAY: begin
          if (tick) begin
            if (dcnt == 3'd0) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_FETCH;
            end else begin
              dcnt <= dcnt - 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Abort wins over everything above, including a same-cycle start.
      if (stop) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        done     <= 1'b0;
        note_rst <= 1'b0;
        note_clk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for note_sequencer with TICK_DIV=4 and a sync-read pattern memory.
// Latency: expected note_rst/done events carry absolute cycle numbers relative to the start cycle.
// Backpressure: none; stimulus is start/stop/rst and memory contents only.
module tb_note_sequencer;

  localparam int ADDR_W   = 8;
  localparam int TICK_DIV = 4;
  localparam int K_RST    = 1;
  localparam int K_DONE   = 2;

  logic              clk50mhz = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              busy;
  logic              done;
  logic              note_clk;
  logic              note_rst;
  logic [5:0]        note_in;
  logic [2:0]        note_length;
  logic [1:0]        env_atk;
  logic [1:0]        env_dec;
  logic [1:0]        fx_sel;
  logic [1:0]        fx_optA;
  logic [1:0]        fx_optB;

  logic [23:0] mem [256];

  note_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk50mhz(clk50mhz), .rst(rst), .start(start), .stop(stop),
    .start_addr(start_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .note_clk(note_clk), .note_rst(note_rst),
    .note_in(note_in), .note_length(note_length), .env_atk(env_atk),
    .env_dec(env_dec), .fx_sel(fx_sel), .fx_optA(fx_optA), .fx_optB(fx_optB)
  );

  always #5 clk50mhz = ~clk50mhz;

  // Sync-read pattern memory: data follows the address by one cycle.
  always @(posedge clk50mhz) rom_data <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk50mhz) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [18:0] fields;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ev_note(input int n, input int len, input int atk, input int dec,
                                          input int fx, input int a, input int b, input int d);
    return {2'b00, 6'(n), 3'(len), 2'(atk), 2'(dec), 2'(fx), 2'(a), 2'(b), 3'(d)};
  endfunction
  function automatic logic [23:0] ev_rest(input int d);
    return {2'b01, 19'd0, 3'(d)};
  endfunction
  function automatic logic [23:0] ev_loop(input int t);
    return {2'b10, 14'd0, 8'(t)};
  endfunction
  function automatic logic [23:0] ev_end();
    return {2'b11, 22'd0};
  endfunction

  task automatic push_rst(input int c, input logic [23:0] w);
    sb.push_back('{K_RST, c, w[21:3]});
  endtask
  task automatic push_done(input int c);
    sb.push_back('{K_DONE, c, 19'd0});
  endtask

  task automatic sb_check(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", kind, 0);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", kind, e.kind);
      chk("sb_cycle", cyc, e.cyc);
      if (kind == K_RST)
        chk("sb_fields", {note_in, note_length, env_atk, env_dec, fx_sel, fx_optA, fx_optB}, e.fields);
    end
  endtask

  always @(negedge clk50mhz) begin
    if (!rst) begin
      if (note_rst) sb_check(K_RST);
      if (done)     sb_check(K_DONE);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk50mhz);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_start(input int addr);
    start_addr = ADDR_W'(addr);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i = 0;
    while (busy && i < limit) begin
      step(1);
      i++;
    end
    chk(tag, busy, 0);
  endtask

  logic [23:0] w0, w1, w2;
  int n;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = ev_end();
    step(3);
    chk("reset_busy", busy, 0);
    chk("reset_ctrl", {done, note_clk, note_rst}, 0);
    chk("reset_addr", rom_addr, 0);
    chk("reset_fields", {note_in, note_length, env_atk, env_dec, fx_sel, fx_optA, fx_optB}, 0);
    rst = 1'b0;
    step(2);

    // Single NOTE dur=1 then END.
    w0 = ev_note(12, 3, 1, 2, 1, 2, 3, 1);
    mem[0] = w0; mem[1] = ev_end();
    n = cyc;
    push_rst(n + 3, w0);
    push_done(n + 20);
    do_start(0);
    chk("t1_busy", busy, 1);
    chk("t1_addr", rom_addr, 0);
    go_to(n + 3);
    chk("t1_note_in", note_in, 12);
    go_to(n + 16);
    chk("t1_addr_hold", rom_addr, 0);
    go_to(n + 17);
    chk("t1_next_fetch", rom_addr, 1);
    wait_idle("t1_idle_timeout", 100);
    step(3);
    chk("t1_sb_left", sb.size(), 0);
    chk("t1_hold_note", note_in, 12);

    // Two NOTEs, dur 0 and 2; a start while busy must be ignored.
    w0 = ev_note(5, 1, 0, 1, 0, 1, 0, 0);
    w1 = ev_note(9, 6, 3, 0, 2, 0, 1, 2);
    mem[0] = w0; mem[1] = w1; mem[2] = ev_end();
    mem[5] = ev_note(63, 7, 3, 3, 3, 3, 3, 0);
    n = cyc;
    push_rst(n + 3, w0);
    push_rst(n + 11, w1);
    push_done(n + 36);
    do_start(0);
    go_to(n + 6);
    do_start(5);
    wait_idle("t2_idle_timeout", 150);
    step(3);
    chk("t2_sb_left", sb.size(), 0);

    // NOTE, REST dur=1, NOTE: outputs held through the rest.
    w0 = ev_note(7, 2, 1, 1, 1, 1, 1, 0);
    w2 = ev_note(20, 4, 2, 3, 0, 3, 2, 0);
    mem[0] = w0; mem[1] = ev_rest(1); mem[2] = w2; mem[3] = ev_end();
    n = cyc;
    push_rst(n + 3, w0);
    push_rst(n + 27, w2);
    push_done(n + 36);
    do_start(0);
    go_to(n + 20);
    chk("t3_rest_hold", note_in, 7);
    wait_idle("t3_idle_timeout", 150);
    step(3);
    chk("t3_sb_left", sb.size(), 0);

    // LOOP back to 0, then stop while the second note is being fetched.
    w0 = ev_note(1, 0, 0, 0, 0, 0, 0, 0);
    w1 = ev_note(2, 5, 1, 2, 3, 1, 2, 0);
    mem[0] = w0; mem[1] = w1; mem[2] = ev_loop(0);
    n = cyc;
    push_rst(n + 3, w0);
    push_rst(n + 11, w1);
    push_rst(n + 27, w0);
    do_start(0);
    go_to(n + 17);
    chk("t4_addr_loop", rom_addr, 2);
    go_to(n + 20);
    chk("t4_addr_target", rom_addr, 0);
    go_to(n + 33);
    chk("t4_addr_after", rom_addr, 1);
    go_to(n + 34);
    chk("t4_clk_high", note_clk, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_clk", note_clk, 0);
    step(30);
    chk("t4_sb_left", sb.size(), 0);

    // start and stop together: stop wins.
    start_addr = 8'd7; start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_addr", rom_addr, 1);
    step(10);
    chk("t5_still_idle", busy, 0);
    chk("t5_sb_left", sb.size(), 0);

    // Address wrap from 255 to 0.
    w0 = ev_note(33, 3, 2, 1, 1, 0, 3, 0);
    mem[255] = w0; mem[0] = ev_end();
    n = cyc;
    push_rst(n + 3, w0);
    push_done(n + 12);
    do_start(255);
    go_to(n + 9);
    chk("t6_wrap_addr", rom_addr, 0);
    wait_idle("t6_idle_timeout", 100);
    step(3);
    chk("t6_sb_left", sb.size(), 0);

    // rst mid-song clears every output.
    w0 = ev_note(40, 7, 3, 3, 3, 3, 3, 3);
    mem[0] = w0; mem[1] = ev_end();
    n = cyc;
    push_rst(n + 3, w0);
    do_start(0);
    go_to(n + 10);
    chk("t7_before_rst", note_in, 40);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_ctrl", {done, note_clk, note_rst}, 0);
    chk("t7_rst_addr", rom_addr, 0);
    chk("t7_rst_fields", {note_in, note_length, env_atk, env_dec, fx_sel, fx_optA, fx_optB}, 0);
    step(40);
    chk("t7_idle", busy, 0);
    chk("t7_sb_left", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
